// File: rtl/leaf_stream_arbiter.sv
// leaf_stream_arbiter
//
// Round-robin arbiter that shares one leaf user-to-interface output port
// between NUM_IN HLS operator output streams (ap_vld/ap_ack style). A grant
// stays with one stream for at most BURST_MAX consecutive words. It ends
// earlier if that stream stops presenting data. Each release costs one
// arbitration cycle. The winning stream index goes out alongside the data.
//
// Ports (all in the clk_user domain):
//   clk_user  in   user clock, rising edge
//   reset     in   synchronous active-low reset (0 = reset)
//   in_data   in   NUM_IN packed words; stream i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   in_vld    in   per-stream valid (Output_*_ap_vld)
//   in_ack    out  per-stream accept (Output_*_ap_ack), combinational
//   out_data  out  registered word to din_leaf_user2interface
//   out_src   out  registered index of the stream that produced out_data
//   out_vld   out  registered valid to vld_user2interface
//   out_ack   in   accept from ack_interface2user

module leaf_stream_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int SRC_BITS     = 2,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_MAX    = 8
) (
  input  logic                           clk_user,
  input  logic                           reset,
  input  logic [NUM_IN*PAYLOAD_BITS-1:0] in_data,
  input  logic [NUM_IN-1:0]              in_vld,
  output logic [NUM_IN-1:0]              in_ack,
  output logic [PAYLOAD_BITS-1:0]        out_data,
  output logic [SRC_BITS-1:0]            out_src,
  output logic                           out_vld,
  input  logic                           out_ack
);

  // LOCKED is the grant_on flag: a stream currently owns the output port.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      grant_on;
  logic [SRC_BITS-1:0]       grant_idx;
  logic [SRC_BITS-1:0]       last_idx;
  logic [7:0]                burst_cnt;

  logic [SRC_BITS-1:0]       pick_idx;
  logic                      pick_vld;
  logic                      sel_vld;
  logic [PAYLOAD_BITS-1:0]   sel_data;
  logic                      room;
  logic                      accept;
  logic                      burst_end;
  logic                      release_grant;

  assign grant_on = (state == LOCKED);

  // The output register can take a new word when it is empty or being drained.
  assign room = ~out_vld | out_ack;

  // Mux the granted stream's valid and data.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SRC_BITS'(i)) begin
        sel_vld  = in_vld[i];
        sel_data = in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Round-robin scan starting just after the last released stream.
  always_comb begin
    logic [SRC_BITS-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = SRC_BITS'((int'(last_idx) + k) % NUM_IN);
      if (!pick_vld && in_vld[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Gating with reset keeps in_ack low in a reset cycle even though the
  // state register only clears at the end of that cycle.
  assign accept        = grant_on & sel_vld & room & reset;
  assign burst_end     = ({1'b0, burst_cnt} + 9'd1) == 9'(BURST_MAX);
  assign release_grant = grant_on & ((accept & burst_end) | (~sel_vld & room));

  always_comb begin
    in_ack = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ack[i] = accept & (grant_idx == SRC_BITS'(i));
    end
  end

  // FSM state register
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)      state_nxt = LOCKED;
      LOCKED:  if (release_grant) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      grant_idx <= '0;
      last_idx  <= SRC_BITS'(NUM_IN - 1);
      burst_cnt <= '0;
    end else if (!grant_on) begin
      if (pick_vld) begin
        grant_idx <= pick_idx;
        burst_cnt <= '0;
      end
    end else begin
      if (accept) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (release_grant) begin
        last_idx <= grant_idx;
      end
    end
  end

  // Output register stage: in_ack to out_vld is one cycle
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_data <= sel_data;
      out_src  <= grant_idx;
    end else if (out_ack) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Self-checking bench for leaf_stream_arbiter: a transaction-level model of the
// grant policy plus a FIFO scoreboard, compared every cycle, and directed
// scenarios with hand-computed cycle/data expectations.

module tb_leaf_stream_arbiter;

  localparam int NUM_IN    = 4;
  localparam int SRC_BITS  = 2;
  localparam int PW        = 32;
  localparam int BURST_MAX = 8;

  logic                   clk_user = 1'b0;
  logic                   reset;
  logic [NUM_IN*PW-1:0]   in_data;
  logic [NUM_IN-1:0]      in_vld;
  logic [NUM_IN-1:0]      in_ack;
  logic [PW-1:0]          out_data;
  logic [SRC_BITS-1:0]    out_src;
  logic                   out_vld;
  logic                   out_ack;

  always #5 clk_user = ~clk_user;

  leaf_stream_arbiter #(
    .NUM_IN       (NUM_IN),
    .SRC_BITS     (SRC_BITS),
    .PAYLOAD_BITS (PW),
    .BURST_MAX    (BURST_MAX)
  ) dut (
    .clk_user (clk_user),
    .reset    (reset),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_ack   (in_ack),
    .out_data (out_data),
    .out_src  (out_src),
    .out_vld  (out_vld),
    .out_ack  (out_ack)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Producers: one word queue per stream, presented while enabled.
  logic [PW-1:0]     src_q [NUM_IN][$];
  bit                en    [NUM_IN];
  logic [NUM_IN-1:0] ack_s = '0;

  task automatic drive();
    for (int i = 0; i < NUM_IN; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        in_vld[i]           = 1'b1;
        in_data[i*PW +: PW] = src_q[i][0];
      end else begin
        in_vld[i]           = 1'b0;
        in_data[i*PW +: PW] = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    for (int i = 0; i < NUM_IN; i++)
      if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    #1;
    drive();
  endtask

  // Transaction model of the arbiter policy.
  typedef struct {
    int            cyc;
    int            src;
    logic [PW-1:0] data;
  } xfer_t;

  int            m_owner = -1;   // -1: nobody holds the port
  int            m_cnt   = 0;
  int            m_last  = NUM_IN - 1;
  bit            m_ov    = 1'b0;
  logic [PW-1:0] m_od    = '0;
  int            m_os    = 0;
  bit            chk_en  = 1'b0;
  int            ncyc    = 0;
  int            t0      = 0;
  xfer_t         xlog[$];
  xfer_t         sb[$];

  always @(negedge clk_user) begin
    logic [NUM_IN-1:0] exp_ack;
    bit                room;
    xfer_t             x;
    room    = !m_ov || out_ack;
    exp_ack = '0;
    if (reset && m_owner >= 0 && in_vld[m_owner] && room) exp_ack[m_owner] = 1'b1;

    if (chk_en) begin
      chk("in_ack", in_ack, exp_ack);
      chk("out_vld", out_vld, m_ov);
      if (m_ov) begin
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
      end
      if (out_vld && out_ack) begin
        if (sb.size() == 0) chk("sb_spurious_word", sb.size(), 1);
        else begin
          x = sb.pop_front();
          chk("sb_src", out_src, x.src);
          chk("sb_data", out_data, x.data);
        end
        x.cyc = ncyc; x.src = int'(out_src); x.data = out_data;
        xlog.push_back(x);
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_ack[i]) begin
          x.cyc = ncyc; x.src = i; x.data = in_data[i*PW +: PW];
          sb.push_back(x);
        end
      end
    end
    ack_s = in_ack;

    if (!reset) begin
      m_owner = -1; m_cnt = 0; m_last = NUM_IN - 1;
      m_ov = 1'b0; m_od = '0; m_os = 0;
      sb.delete();
    end else if (m_owner < 0) begin
      if (m_ov && out_ack) m_ov = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
        if (m_owner < 0 && in_vld[(m_last + k) % NUM_IN]) begin
          m_owner = (m_last + k) % NUM_IN;
          m_cnt   = 0;
        end
      end
    end else if (exp_ack != '0) begin
      m_ov = 1'b1;
      m_od = in_data[m_owner*PW +: PW];
      m_os = m_owner;
      m_cnt++;
      if (m_cnt == BURST_MAX) begin m_last = m_owner; m_owner = -1; end
    end else begin
      if (m_ov && out_ack) m_ov = 1'b0;
      if (!in_vld[m_owner] && room) begin m_last = m_owner; m_owner = -1; end
    end
    ncyc++;
  end

  function automatic int lc(input int k);
    if (k < xlog.size()) return xlog[k].cyc - t0;
    return -99;
  endfunction

  function automatic int ls(input int k);
    if (k < xlog.size()) return xlog[k].src;
    return -1;
  endfunction

  function automatic logic [PW-1:0] ld(input int k);
    if (k < xlog.size()) return xlog[k].data;
    return '1;
  endfunction

  task automatic do_reset();
    reset   = 1'b0;
    out_ack = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      en[i] = 1'b0;
      src_q[i].delete();
    end
    drive();
    step();
    step();
  endtask

  // Leaves the bench at cycle 0 of a new scenario.
  task automatic go();
    out_ack = 1'b1;
    reset   = 1'b1;
    drive();
    t0 = ncyc;
    xlog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk_en = 1'b1;
    @(negedge clk_user);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    step();

    // Single stream with a burst boundary and regrant
    for (int n = 1; n <= 10; n++) src_q[0].push_back(n);
    en[0] = 1'b1;
    go();
    repeat (16) step();
    chk("t1_first_cyc", lc(0), 2);
    chk("t1_first_src", ls(0), 0);
    chk("t1_first_data", ld(0), 32'h1);
    chk("t1_w8_cyc", lc(7), 9);
    chk("t1_w8_data", ld(7), 32'h8);
    chk("t1_regrant_cyc", lc(8), 11);
    chk("t1_regrant_data", ld(8), 32'h9);
    chk("t1_count", xlog.size(), 10);

    // Fairness with all streams busy
    do_reset();
    for (int i = 0; i < NUM_IN; i++) begin
      for (int n = 1; n <= 16; n++) src_q[i].push_back((i << 8) | n);
      en[i] = 1'b1;
    end
    go();
    repeat (80) step();
    chk("t2_count", xlog.size(), 64);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("t2_src[%0d]", k), ls(k), (k / 8) % 4);
      chk($sformatf("t2_data[%0d]", k), ld(k), (((k / 8) % 4) << 8) | ((k / 32) * 8 + k % 8 + 1));
      if (k > 0) chk($sformatf("t2_gap[%0d]", k), lc(k) - lc(k - 1), (k % 8 == 0) ? 2 : 1);
    end

    // Backpressure for 5 cycles mid-burst
    do_reset();
    for (int n = 1; n <= 12; n++) src_q[1].push_back(32'h100 | n);
    en[1] = 1'b1;
    go();
    repeat (4) step();
    out_ack = 1'b0;
    repeat (2) step();
    @(negedge clk_user);
    chk("t3_stall_in_ack", in_ack, 0);
    chk("t3_stall_out_vld", out_vld, 1);
    chk("t3_stall_out_data", out_data, 32'h103);
    repeat (3) step();
    out_ack = 1'b1;
    repeat (16) step();
    chk("t3_count", xlog.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t3_data[%0d]", k), ld(k), 32'h101 + k);
      chk($sformatf("t3_src[%0d]", k), ls(k), 1);
    end
    chk("t3_w2_cyc", lc(1), 3);
    chk("t3_w3_cyc", lc(2), 9);
    chk("t3_w4_cyc", lc(3), 10);
    chk("t3_w9_cyc", lc(8), 16);

    // Early release of stream 2, then a full burst of stream 3
    do_reset();
    for (int n = 1; n <= 3; n++)  src_q[2].push_back(32'h200 | n);
    for (int n = 1; n <= 12; n++) src_q[3].push_back(32'h300 | n);
    en[2] = 1'b1;
    en[3] = 1'b1;
    go();
    repeat (24) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_s2_src[%0d]", k), ls(k), 2);
      chk($sformatf("t4_s2_data[%0d]", k), ld(k), 32'h201 + k);
    end
    chk("t4_s2_last_cyc", lc(2), 4);
    chk("t4_s3_first_cyc", lc(3), 7);
    for (int k = 3; k < 11; k++) begin
      chk($sformatf("t4_s3_src[%0d]", k), ls(k), 3);
      chk($sformatf("t4_s3_data[%0d]", k), ld(k), 32'h301 + (k - 3));
    end
    chk("t4_regrant_gap", lc(11) - lc(10), 2);
    chk("t4_regrant_data", ld(11), 32'h309);
    chk("t4_count", xlog.size(), 15);

    // Reset asserted for one cycle while stream 1 is four words into its burst
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      src_q[1].push_back(32'h100 | n);
      src_q[3].push_back(32'h300 | n);
    end
    en[1] = 1'b1;
    en[3] = 1'b1;
    go();
    repeat (5) step();
    reset   = 1'b0;
    out_ack = 1'b0;
    step();
    reset   = 1'b1;
    out_ack = 1'b1;
    @(negedge clk_user);
    chk("t5_post_rst_out_vld", out_vld, 0);
    chk("t5_post_rst_in_ack", in_ack, 0);
    repeat (6) step();
    chk("t5_pre_rst_last_cyc", lc(2), 4);
    chk("t5_pre_rst_last_data", ld(2), 32'h103);
    chk("t5_regrant_src", ls(3), 1);
    chk("t5_regrant_data", ld(3), 32'h105);
    chk("t5_regrant_cyc", lc(3), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_stream_arbiter.md
# leaf_stream_arbiter

Round-robin arbiter that shares the single user-to-interface output port of a leaf between up to NUM_IN HLS operator output streams. It sits between the operators' ap_vld/ap_ack output streams and the leaf_interface `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` port, all in the clk_user domain. Each grant is held for a bounded burst so one operator cannot starve the others. The selected source index is exported alongside the data.

## Interface
- NUM_IN, 4: number of requesting streams (2..16)
- SRC_BITS, 2: width of source index; must equal clog2(NUM_IN)
- PAYLOAD_BITS, 32: stream word width
- BURST_MAX, 8: maximum consecutive words per grant (1..255)

- clk_user  in  1  user clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- in_data  in  NUM_IN*PAYLOAD_BITS  stream i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- in_vld  in  NUM_IN  per-stream valid (operator Output_*_ap_vld)
- in_ack  out  NUM_IN  per-stream accept (operator Output_*_ap_ack)
- out_data  out  PAYLOAD_BITS  to din_leaf_user2interface
- out_src  out  SRC_BITS  index of the stream that produced out_data
- out_vld  out  1  to vld_user2interface
- out_ack  in  1  from ack_interface2user

## Operation
- Handshake on both sides: a transfer occurs in a cycle where vld and ack are both 1. Producers hold data stable while vld=1 and ack=0.
- Registers:
  - grant_idx (SRC_BITS)
  - grant_on (1)
  - last_idx (SRC_BITS)
  - burst_cnt (8 bits)
  - output register: out_data, out_src, out_vld
- States: IDLE (grant_on=0) and LOCKED (grant_on=1).
- IDLE: if any in_vld is 1, choose the first set in_vld scanning last_idx+1, last_idx+2, … modulo NUM_IN.
  - Set grant_idx to that index, grant_on=1, burst_cnt=0.
  - If no in_vld is set, stay in IDLE.
- LOCKED:
  - in_ack[grant_idx] = in_vld[grant_idx] & (~out_vld | out_ack), combinational. All other in_ack bits are 0.
  - In IDLE all in_ack bits are 0.
  - On each accepted word:
    - out_data ← in_data[grant_idx]
    - out_src ← grant_idx
    - out_vld ← 1
    - burst_cnt increments
  - out_vld clears on an out_ack cycle in which no new word is accepted.
- Release: go to IDLE with last_idx ← grant_idx when either:
  - (a) a word is accepted and burst_cnt+1 == BURST_MAX, or
  - (b) in_vld[grant_idx]=0 during a cycle where the output register could accept (~out_vld | out_ack).
- A stalled output (out_vld=1, out_ack=0) never causes release. The grant waits.
- Words from different streams are never reordered. Words within one stream stay in order.

## Timing
- Reset values:
  - out_vld=0, out_data=0, out_src=0, in_ack=0
  - grant_on=0, grant_idx=0, burst_cnt=0
  - last_idx=NUM_IN-1, so input 0 has first priority
- Latency:
  - in_vld rising in IDLE at cycle C: grant registered at end of C, in_ack=1 in C+1, out_vld=1 in C+2.
  - Within a burst: one word per cycle, in_ack to out_vld is 1 cycle.
- Full throughput: out_ack held 1 with a continuously valid source gives a word every cycle.
- Each release costs exactly one IDLE arbitration cycle, so each grant adds one bubble.
- Simultaneous events:
  - Release by (a) while another stream requests: that stream is granted in the IDLE cycle that follows.
  - Releasing stream still valid and the only requester: it is regranted with burst_cnt=0.
- Reset asserted mid-burst: all registers return to reset values on that edge. in_ack is 0 during reset. A word held in the output register is discarded.
- BURST_MAX=1 degenerates to strict per-word round robin with a bubble between words.

## Test plan
- Single stream: reset released, in_vld[0]=1 with data 0x1..0x8, out_ack=1.
  - out_vld first at cycle 2, out_src=0, words 0x1..0x8 on consecutive cycles.
  - Release after 0x8, one bubble, then regrant of stream 0.
- Fairness: all 4 streams continuously valid, out_ack=1, BURST_MAX=8.
  - out_src sequence 0×8, 1×8, 2×8, 3×8, 0×8…, each block separated by one bubble.
- Backpressure: out_ack=0 for 5 cycles mid-burst.
  - out_data/out_src held stable, in_ack=0, no release, no lost or duplicated word.
  - Burst resumes when out_ack=1.
- Early release: stream 2 drops in_vld after 3 words while stream 3 is valid.
  - Stream 3 granted next with burst_cnt=0, and stream 2's 3 words all precede stream 3's words.
- Reset mid-burst: assert reset for 1 cycle while stream 1 is at burst_cnt=4.
  - Next cycle out_vld=0, in_ack=0, and the first grant afterwards goes to the lowest valid index.
